mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port synchronous RAM between the instruction-fetch port and the load/store (MEM-stage) port. This replaces the dual-port RAM arrangement.
- Grants one access per cycle using fixed data-over-instruction priority plus an anti-starvation streak counter.
- Routes each 1-cycle-latency read response back to the requester that issued it.
- Drives a stall request to pipe_ctrl whenever a requester is denied.

Parameters:
- ADDR_WIDTH, 32, byte-address width of both requester ports.
- DATA_WIDTH, 32, RAM word and data width.
- RAM_AW, 12, RAM word-address width (RAM depth is 4096 words).
- MAX_DATA_STREAK, 4, maximum consecutive data grants while an instruction request is waiting.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset. One clock; reset is synchronous and active-high.
- inst_req_i  in  1  instruction read request.
- inst_addr_i  in  ADDR_WIDTH  instruction byte address.
- inst_gnt_o  out  1  instruction request accepted this cycle.
- inst_rvalid_o  out  1  instruction read data valid.
- inst_rdata_o  out  DATA_WIDTH  instruction word.
- data_req_i  in  1  load/store request.
- data_we_i  in  1  1 = store, 0 = load.
- data_be_i  in  4  store byte enables.
- data_addr_i  in  ADDR_WIDTH  data byte address.
- data_wdata_i  in  DATA_WIDTH  store data.
- data_gnt_o  out  1  data request accepted this cycle.
- data_rvalid_o  out  1  load data valid.
- data_rdata_o  out  DATA_WIDTH  load word.
- data_err_o  out  1  accompanies data_rvalid_o, or pulses with the grant of a store; out-of-range address.
- ram_ce_o  out  1  RAM enable.
- ram_we_o  out  1  RAM write enable.
- ram_be_o  out  4  RAM byte enables.
- ram_addr_o  out  RAM_AW  RAM word address.
- ram_wdata_o  out  DATA_WIDTH  RAM write data.
- ram_rdata_i  in  DATA_WIDTH  RAM read data, valid 1 cycle after ce with we = 0.
- stallreq_o  out  1  stall request to pipe_ctrl.

Behaviour:
- Grant logic is combinational from the requests and registered state. inst_gnt_o and data_gnt_o are never both 1.
- Arbitration, evaluated in order:
  - data_req_i only -> data granted.
  - inst_req_i only -> inst granted.
  - both, and streak_cnt < MAX_DATA_STREAK -> data granted.
  - both, and streak_cnt == MAX_DATA_STREAK -> inst granted.
- streak_cnt register (width clog2(MAX_DATA_STREAK+1)):
  - increments on a data grant while inst_req_i is 1.
  - clears on any inst grant, or when inst_req_i is 0.
  - saturates at MAX_DATA_STREAK.
- RAM drive:
  - on a grant: ram_ce_o = 1 and ram_addr_o = addr[RAM_AW+1:2]. Bits [1:0] are ignored.
  - a data store also drives ram_we_o = 1, ram_be_o = data_be_i, ram_wdata_o = data_wdata_i.
  - with no grant: ram_ce_o = 0, ram_we_o = 0, ram_be_o = 0.
- Range check: data address is out of range when addr[ADDR_WIDTH-1:RAM_AW+2] != 0.
  - the request is still granted, but ram_ce_o stays 0.
  - a load returns data_rvalid_o = 1, data_rdata_o = 0, data_err_o = 1 one cycle later.
  - a store pulses data_err_o in the grant cycle.
  - instruction addresses are not range-checked.
- Response routing uses a registered tag resp_owner ∈ {NONE, INST, DATA, DATA_ERR}, set at each grant cycle:
  - INST on an inst grant.
  - DATA on a load grant.
  - DATA_ERR on an out-of-range load grant.
  - NONE for a store or no grant.
- Responses in the following cycle:
  - INST -> inst_rvalid_o = 1, inst_rdata_o = ram_rdata_i.
  - DATA -> data_rvalid_o = 1, data_rdata_o = ram_rdata_i.
  - DATA_ERR -> data_rvalid_o = 1, data_rdata_o = 0, data_err_o = 1.
  - rdata outputs are 0 when the matching rvalid is 0.
- Throughput and latency:
  - back-to-back grants every cycle are allowed, with the response to grant N overlapping grant N+1.
  - read latency is exactly 1 cycle from grant to rvalid.
  - a store completes at its grant edge.
- stallreq_o = (inst_req_i & ~inst_gnt_o) | (data_req_i & ~data_gnt_o). It is purely combinational with no registered delay.
- Requesters hold req and payload stable until granted. The arbiter does not latch ungranted requests.
- Reset (synchronous, rst_i = 1):
  - streak_cnt = 0 and resp_owner = NONE.
  - all gnt, rvalid, err and ram_* outputs = 0.
  - a read granted in the cycle before reset produces no rvalid.
  - while rst_i = 1, requests are ignored and no grants are issued.

Decomposition:
- Shared defines (defines.v):
  - RESP_NONE / RESP_INST / RESP_DATA / RESP_DERR 2-bit encodings.
  - reuse of `ADDR_WIDTH and `DATA_WIDTH.
- Single module, no sub-module. The priority/streak logic is kept in one always block; the response mux is a separate combinational block.

Test Plan:
- Inst only: inst_req at 0x0000_0010 with RAM[4] = 0x0000_0013 -> gnt the same cycle, ram_addr = 4, inst_rvalid next cycle with rdata 0x13; stallreq = 0.
- Conflict: inst 0x100 and data load 0x200 both requesting for 1 cycle -> data_gnt = 1, inst_gnt = 0, stallreq = 1. The next cycle with only inst requesting -> inst granted, stallreq = 0.
- Starvation: both requesting continuously with MAX_DATA_STREAK = 4 -> grant pattern D,D,D,D,I,D,D,D,D,I; streak_cnt returns to 0 after each I.
- Store then load to the same word: store 0xDEADBEEF with be = 4'b0011 to 0x40 over old 0x11223344, then load 0x40 -> data_rvalid with rdata 0x1122BEEF.
- Out of range: load at 0x0001_0000 (RAM_AW = 12) -> ram_ce = 0, next cycle data_rvalid = 1, data_err = 1, rdata = 0. Store there -> data_err pulses in the grant cycle and the RAM is unchanged.
- Reset mid-read: assert rst_i the cycle after an inst grant -> inst_rvalid stays 0; after release, the first grant behaves as in scenario 1.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the single-port RAM arbiter: default geometry and
// the response-owner tag that routes a read result back to its requester.
package mem_arbiter_pkg;

    localparam int DEF_ADDR_WIDTH      = 32;
    localparam int DEF_DATA_WIDTH      = 32;
    localparam int DEF_RAM_AW          = 12;
    localparam int DEF_MAX_DATA_STREAK = 4;

    // Who owns the RAM read data arriving in the next cycle
    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_INST = 2'd1,
        RESP_DATA = 2'd2,
        RESP_DERR = 2'd3
    } resp_owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port synchronous RAM between instruction fetch and
// load/store. Data wins by default; a streak counter guarantees the fetch
// port a slot after MAX_DATA_STREAK consecutive data grants while it waits.
// Read responses return one cycle after the grant, steered by a registered
// owner tag. Out-of-range data accesses are granted but never reach the RAM.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int RAM_AW          = DEF_RAM_AW,
    parameter int MAX_DATA_STREAK = DEF_MAX_DATA_STREAK
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  inst_req_i,
    input  logic [ADDR_WIDTH-1:0] inst_addr_i,
    output logic                  inst_gnt_o,
    output logic                  inst_rvalid_o,
    output logic [DATA_WIDTH-1:0] inst_rdata_o,
    input  logic                  data_req_i,
    input  logic                  data_we_i,
    input  logic [3:0]            data_be_i,
    input  logic [ADDR_WIDTH-1:0] data_addr_i,
    input  logic [DATA_WIDTH-1:0] data_wdata_i,
    output logic                  data_gnt_o,
    output logic                  data_rvalid_o,
    output logic [DATA_WIDTH-1:0] data_rdata_o,
    output logic                  data_err_o,
    output logic                  ram_ce_o,
    output logic                  ram_we_o,
    output logic [3:0]            ram_be_o,
    output logic [RAM_AW-1:0]     ram_addr_o,
    output logic [DATA_WIDTH-1:0] ram_wdata_o,
    input  logic [DATA_WIDTH-1:0] ram_rdata_i,
    output logic                  stallreq_o
);

    localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

    logic [STREAK_W-1:0] r_streakCnt;
    resp_owner_t         r_respOwner;

    logic                w_instGnt;
    logic                w_dataGnt;
    logic                w_dataOor;
    logic [STREAK_W-1:0] w_streakNext;
    resp_owner_t         w_respNext;
    logic                w_unused;

    // Fetch addresses are never range-checked and byte offsets are dropped
    assign w_unused  = ^{inst_addr_i[ADDR_WIDTH-1:RAM_AW+2], inst_addr_i[1:0], data_addr_i[1:0]};
    assign w_dataOor = |data_addr_i[ADDR_WIDTH-1:RAM_AW+2];

    // Priority decision and streak bookkeeping; nothing is granted during reset
    always_comb begin
        w_instGnt    = 1'b0;
        w_dataGnt    = 1'b0;
        w_streakNext = '0;
        if (!rst_i) begin
            if (data_req_i && (!inst_req_i || (r_streakCnt < STREAK_MAX))) begin
                w_dataGnt = 1'b1;
            end else if (inst_req_i) begin
                w_instGnt = 1'b1;
            end
            if (inst_req_i && w_dataGnt) begin
                w_streakNext = (r_streakCnt == STREAK_MAX) ? STREAK_MAX : r_streakCnt + 1'b1;
            end
        end
    end

    // Decide who will own the read data returned next cycle
    always_comb begin
        w_respNext = RESP_NONE;
        if (w_instGnt) begin
            w_respNext = RESP_INST;
        end else if (w_dataGnt && !data_we_i) begin
            w_respNext = w_dataOor ? RESP_DERR : RESP_DATA;
        end
    end

    // Drive the RAM from the granted port; out-of-range data never enables it
    always_comb begin
        ram_ce_o    = 1'b0;
        ram_we_o    = 1'b0;
        ram_be_o    = 4'b0000;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        if (w_instGnt) begin
            ram_ce_o   = 1'b1;
            ram_addr_o = inst_addr_i[RAM_AW+1:2];
        end else if (w_dataGnt) begin
            ram_addr_o = data_addr_i[RAM_AW+1:2];
            if (!w_dataOor) begin
                ram_ce_o = 1'b1;
                if (data_we_i) begin
                    ram_we_o    = 1'b1;
                    ram_be_o    = data_be_i;
                    ram_wdata_o = data_wdata_i;
                end
            end
        end
    end

    // Arbitration state: streak count and response owner tag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_streakCnt <= '0;
            r_respOwner <= RESP_NONE;
        end else begin
            r_streakCnt <= w_streakNext;
            r_respOwner <= w_respNext;
        end
    end

    // Route the RAM read data (or an error response) to the owning port
    always_comb begin
        inst_rvalid_o = 1'b0;
        inst_rdata_o  = '0;
        data_rvalid_o = 1'b0;
        data_rdata_o  = '0;
        data_err_o    = w_dataGnt && data_we_i && w_dataOor;
        if (!rst_i) begin
            case (r_respOwner)
                RESP_INST: begin
                    inst_rvalid_o = 1'b1;
                    inst_rdata_o  = ram_rdata_i;
                end
                RESP_DATA: begin
                    data_rvalid_o = 1'b1;
                    data_rdata_o  = ram_rdata_i;
                end
                RESP_DERR: begin
                    data_rvalid_o = 1'b1;
                    data_err_o    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign inst_gnt_o = w_instGnt;
    assign data_gnt_o = w_dataGnt;
    assign stallreq_o = (inst_req_i & ~w_instGnt) | (data_req_i & ~w_dataGnt);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a behavioural RAM plus a shadow-memory
// reference model that predicts grants, RAM drive and read responses.
module tb_mem_arbiter;

    localparam int MAXS = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        inst_req_i = 1'b0;
    logic [31:0] inst_addr_i = '0;
    logic        inst_gnt_o, inst_rvalid_o;
    logic [31:0] inst_rdata_o;
    logic        data_req_i = 1'b0, data_we_i = 1'b0;
    logic [3:0]  data_be_i = '0;
    logic [31:0] data_addr_i = '0, data_wdata_i = '0;
    logic        data_gnt_o, data_rvalid_o, data_err_o;
    logic [31:0] data_rdata_o;
    logic        ram_ce_o, ram_we_o;
    logic [3:0]  ram_be_o;
    logic [11:0] ram_addr_o;
    logic [31:0] ram_wdata_o;
    logic [31:0] ram_rdata_i = '0;
    logic        stallreq_o;

    logic [31:0] tbRam     [0:4095];
    logic [31:0] shadowMem [0:4095];

    int          assertCount = 0;
    int          failCount   = 0;
    int          waitStreak  = 0;
    bit          pendInst = 0, pendData = 0, pendErr = 0;
    logic [31:0] pendRdata = '0;
    bit          lastInstGnt = 0, lastDataGnt = 0;

    always #5 clk_i = ~clk_i;

    mem_arbiter dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .inst_req_i(inst_req_i), .inst_addr_i(inst_addr_i), .inst_gnt_o(inst_gnt_o),
        .inst_rvalid_o(inst_rvalid_o), .inst_rdata_o(inst_rdata_o),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
        .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
        .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_be_o(ram_be_o),
        .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i),
        .stallreq_o(stallreq_o)
    );

    // Single-port synchronous RAM with byte-enable writes and 1-cycle reads
    always @(posedge clk_i) begin
        if (ram_ce_o) begin
            if (ram_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be_o[b]) tbRam[ram_addr_o][b*8 +: 8] <= ram_wdata_o[b*8 +: 8];
            end else begin
                ram_rdata_i <= tbRam[ram_addr_o];
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic bit isOor(input logic [31:0] a);
        return a[31:14] != 18'd0;
    endfunction

    // One normal cycle: drive requests, check against the model, advance the model
    task automatic applyStimulus(input bit iReq, input logic [31:0] iAddr, input bit dReq,
                                 input bit dWe, input logic [3:0] dBe, input logic [31:0] dAddr,
                                 input logic [31:0] dWdata);
        bit          expI, expD, oor, expCe, expWe;
        logic [11:0] expAddr;
        @(negedge clk_i);
        rst_i = 1'b0;
        inst_req_i = iReq; inst_addr_i = iAddr;
        data_req_i = dReq; data_we_i = dWe; data_be_i = dBe;
        data_addr_i = dAddr; data_wdata_i = dWdata;
        #1;
        oor   = isOor(dAddr);
        expD  = dReq && (!iReq || waitStreak < MAXS);
        expI  = iReq && !expD;
        expCe = expI || (expD && !oor);
        expWe = expD && dWe && !oor;
        expAddr = expI ? iAddr[13:2] : dAddr[13:2];
        checkOutput("inst_gnt", 32'(inst_gnt_o), 32'(expI));
        checkOutput("data_gnt", 32'(data_gnt_o), 32'(expD));
        checkOutput("stallreq", 32'(stallreq_o), 32'((iReq && !expI) || (dReq && !expD)));
        checkOutput("inst_rvalid", 32'(inst_rvalid_o), 32'(pendInst));
        checkOutput("inst_rdata", inst_rdata_o, pendInst ? pendRdata : 32'h0);
        checkOutput("data_rvalid", 32'(data_rvalid_o), 32'(pendData));
        checkOutput("data_rdata", data_rdata_o, pendData ? pendRdata : 32'h0);
        checkOutput("data_err", 32'(data_err_o), 32'(pendErr || (expD && dWe && oor)));
        checkOutput("ram_ce", 32'(ram_ce_o), 32'(expCe));
        checkOutput("ram_we", 32'(ram_we_o), 32'(expWe));
        checkOutput("ram_be", 32'(ram_be_o), expWe ? 32'(dBe) : 32'h0);
        if (expCe) checkOutput("ram_addr", 32'(ram_addr_o), 32'(expAddr));
        if (expWe) checkOutput("ram_wdata", ram_wdata_o, dWdata);

        lastInstGnt = expI;
        lastDataGnt = expD;
        pendInst = 0; pendData = 0; pendErr = 0; pendRdata = '0;
        if (expI) begin
            pendInst  = 1;
            pendRdata = shadowMem[iAddr[13:2]];
        end else if (expD) begin
            if (dWe) begin
                if (!oor)
                    for (int b = 0; b < 4; b++)
                        if (dBe[b]) shadowMem[dAddr[13:2]][b*8 +: 8] = dWdata[b*8 +: 8];
            end else begin
                pendData = 1;
                if (oor) pendErr = 1;
                else     pendRdata = shadowMem[dAddr[13:2]];
            end
        end
        // Consecutive data wins while the fetch port keeps waiting
        waitStreak = (iReq && expD) ? ((waitStreak + 1 > MAXS) ? MAXS : waitStreak + 1) : 0;
    endtask

    // One reset cycle: everything quiet, any outstanding read is dropped
    task automatic resetCycle(input bit iReq, input logic [31:0] iAddr);
        @(negedge clk_i);
        rst_i = 1'b1;
        inst_req_i = iReq; inst_addr_i = iAddr;
        data_req_i = 1'b0; data_we_i = 1'b0;
        #1;
        checkOutput("rst_inst_gnt", 32'(inst_gnt_o), 32'h0);
        checkOutput("rst_data_gnt", 32'(data_gnt_o), 32'h0);
        checkOutput("rst_ram_ce", 32'(ram_ce_o), 32'h0);
        checkOutput("rst_ram_we", 32'(ram_we_o), 32'h0);
        checkOutput("rst_inst_rvalid", 32'(inst_rvalid_o), 32'h0);
        checkOutput("rst_data_rvalid", 32'(data_rvalid_o), 32'h0);
        checkOutput("rst_data_err", 32'(data_err_o), 32'h0);
        pendInst = 0; pendData = 0; pendErr = 0; pendRdata = '0;
        waitStreak  = 0;
        lastInstGnt = 0;
        lastDataGnt = 0;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin
        bit          dataPat [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        bit          iPend = 0, dPend = 0, dWe = 0;
        logic [31:0] iA = '0, dA = '0, dW = '0;
        logic [3:0]  dB = '0;

        for (int i = 0; i < 4096; i++) begin
            tbRam[i]     = (i * 32'h9E3779B1) ^ 32'h5A5A0000;
            shadowMem[i] = tbRam[i];
        end
        tbRam[4]  = 32'h00000013; shadowMem[4]  = 32'h00000013;
        tbRam[16] = 32'h11223344; shadowMem[16] = 32'h11223344;

        resetCycle(1'b0, 32'h0);
        resetCycle(1'b0, 32'h0);

        // Instruction-only fetch
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        checkOutput("s1_ram_addr", 32'(ram_addr_o), 32'd4);
        idleCycle();
        checkOutput("s1_inst_rdata", inst_rdata_o, 32'h13);

        // Conflict: data wins, then the fetch goes through
        applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 4'h0, 32'h200, 32'h0);
        checkOutput("conflict_data_gnt", 32'(data_gnt_o), 32'h1);
        checkOutput("conflict_stall", 32'(stallreq_o), 32'h1);
        applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        checkOutput("conflict_inst_gnt", 32'(inst_gnt_o), 32'h1);
        idleCycle();

        // Starvation guard: D,D,D,D,I repeating
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 32'h300, 1'b1, 1'b0, 4'h0, 32'h400, 32'h0);
            checkOutput($sformatf("starve_%0d", i), 32'(data_gnt_o), 32'(dataPat[i]));
        end
        idleCycle();

        // Partial store then load of the same word
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h40, 32'hDEADBEEF);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h40, 32'h0);
        idleCycle();
        checkOutput("merge_rdata", data_rdata_o, 32'h1122BEEF);

        // Out-of-range load and store; word 0 must stay untouched
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h00010000, 32'h0);
        checkOutput("oor_load_ce", 32'(ram_ce_o), 32'h0);
        idleCycle();
        checkOutput("oor_load_err", 32'(data_err_o), 32'h1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h00010000, 32'hCAFEF00D);
        checkOutput("oor_store_err", 32'(data_err_o), 32'h1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
        idleCycle();

        // Reset right after a fetch grant swallows its response
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        resetCycle(1'b1, 32'h10);
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        checkOutput("post_rst_ram_addr", 32'(ram_addr_o), 32'd4);
        idleCycle();
        checkOutput("post_rst_rdata", inst_rdata_o, 32'h13);

        // Random traffic with requests held until granted
        for (int c = 0; c < 800; c++) begin
            if (!iPend && $urandom_range(3) != 0) begin
                iPend = 1;
                iA = ($urandom_range(63) << 2) | $urandom_range(3);
            end
            if (!dPend && $urandom_range(2) != 0) begin
                dPend = 1;
                dWe = 1'($urandom_range(1));
                dB  = 4'($urandom_range(15));
                dW  = $urandom;
                dA  = ($urandom_range(63) << 2) | $urandom_range(3);
                if ($urandom_range(7) == 0) dA = dA | (32'h1 << $urandom_range(31, 14));
            end
            if ($urandom_range(59) == 0) resetCycle(iPend, iA);
            else applyStimulus(iPend, iA, dPend, dWe, dB, dA, dW);
            if (lastInstGnt) iPend = 0;
            if (lastDataGnt) dPend = 0;
        end
        idleCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
